// File: rtl/gate_test_sequencer.sv
// Self-test controller for the trainer-kit gate array: sweeps a/b through 00..11,
// lets each vector settle for DWELL cycles, then checks the seven gate outputs against a golden model.
module gate_test_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  input  logic [6:0] gate_in,
  output logic       a_drv,
  output logic       b_drv,
  output logic [1:0] idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_gates,
  output logic [3:0] fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SAMPLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] L_LAST = 8'(DWELL - 1);

  // Expected gate outputs, bit order AND, OR, NOT_A, NAND, NOR, XOR, XNOR.
  function automatic logic [6:0] golden(input logic a, input logic b);
    golden = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [1:0] r_idx;
  logic [1:0] w_idx_nxt;
  logic [6:0] r_err;
  logic [6:0] w_err_nxt;
  logic [3:0] r_fv;
  logic [3:0] w_fv_nxt;
  logic       r_mode;
  logic       r_go;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [6:0] w_mism;
  logic       w_can_start;
  logic       w_capture;

  assign w_mism      = gate_in ^ golden(r_a, r_b);
  assign w_can_start = (r_state == S_IDLE) || (r_state == S_DONE);
  // A start is registered first so the sweep begins one cycle after the pulse.
  assign w_capture   = start && w_can_start && !r_go;

  assign a_drv     = r_a;
  assign b_drv     = r_b;
  assign idx       = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_gates = r_err;
  assign fail_vec  = r_fv;

  // Next-state and datapath update for the sweep controller.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_fv_nxt    = r_fv;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_go) begin
          w_state_nxt = S_APPLY;
          w_cnt_nxt   = 8'd0;
          w_idx_nxt   = 2'd0;
          w_err_nxt   = 7'd0;
          w_fv_nxt    = 4'd0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_APPLY: begin
        if (r_cnt == L_LAST) begin
          w_state_nxt = S_SAMPLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_SAMPLE: begin
        w_err_nxt = r_err | w_mism;
        w_fv_nxt  = r_fv | ({3'd0, |w_mism} << r_idx);
        if (r_idx == 2'd3) begin
          w_state_nxt = S_DONE;
        end else if (r_mode) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_APPLY;
          w_idx_nxt   = r_idx + 2'd1;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_WAIT: begin
        if (step) begin
          w_state_nxt = S_APPLY;
          w_idx_nxt   = r_idx + 2'd1;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_idx   <= 2'd0;
      r_err   <= 7'd0;
      r_fv    <= 4'd0;
      r_mode  <= 1'b0;
      r_go    <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
      r_fv    <= w_fv_nxt;
      r_go    <= w_capture;
      if (w_capture) begin
        r_mode <= step_mode;
      end
      r_a    <= w_idx_nxt[1];
      r_b    <= w_idx_nxt[0];
      r_busy <= (w_state_nxt == S_APPLY) || (w_state_nxt == S_SAMPLE) || (w_state_nxt == S_WAIT);
      r_done <= (w_state_nxt == S_DONE);
      r_pass <= (w_state_nxt == S_DONE) && (w_err_nxt == 7'd0);
    end
  end

endmodule
